// File: rtl/write_fm_decoder.sv
// FM write-stream decoder: synchronizes the controller write gate and pulse stream, hunts the
// preamble and sync bit, then strobes out one decoded bit per cell.
// Define WR_DEC_ERR_EN to add the sticky err_missing_clk output.
module write_fm_decoder #(
    parameter int CELL_CLKS    = 32,
    parameter int DATA_WIN_LO  = 8,
    parameter int DATA_WIN_HI  = 24,
    parameter int MIN_PREAMBLE = 16,
    parameter int TIMEOUT      = 48
) (
    input  logic clk,
    input  logic rst_n,
    input  logic write_gate,
    input  logic wr_raw,
    output logic wr_data,
    output logic new_data,
    output logic data_area
`ifdef WR_DEC_ERR_EN
    ,
    output logic err_missing_clk
`endif
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);
    localparam int PRE_W = $clog2(MIN_PREAMBLE + 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_HUNT = 2'd1;
    localparam logic [1:0] S_DATA = 2'd2;

    // The data window must sit strictly inside a nominal cell, and the timeout beyond it.
    if (DATA_WIN_LO >= DATA_WIN_HI || DATA_WIN_HI >= CELL_CLKS || CELL_CLKS >= TIMEOUT)
    begin : g_param_check
        $error("write_fm_decoder: inconsistent cell timing parameters");
    end

    logic             gate_s1_q, gate_s2_q;
    logic             raw_s1_q, raw_s2_q, raw_s3_q;
    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] cell_cnt_q, cell_cnt_d;
    logic [PRE_W-1:0] pre_cnt_q, pre_cnt_d;
    logic             data_seen_q, data_seen_d;
    logic             first_cell_q, first_cell_d;
    logic             data_area_q, data_area_d;
    logic             new_data_q, new_data_d;
    logic             wr_data_q, wr_data_d;
    logic             pulse;
    logic             timeout_hit;
    logic             bit_done;
    logic [CNT_W-1:0] cnt_inc;

    // NOTE: every flop, including synchronizer stages, updates with <= so all stages
    // sample the pre-edge values and the chain really is two flops deep.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gate_s1_q <= 1'b0;
            gate_s2_q <= 1'b0;
            raw_s1_q  <= 1'b0;
            raw_s2_q  <= 1'b0;
            raw_s3_q  <= 1'b0;
        end else begin
            gate_s1_q <= write_gate;
            gate_s2_q <= gate_s1_q;
            raw_s1_q  <= wr_raw;
            raw_s2_q  <= raw_s1_q;
            raw_s3_q  <= raw_s2_q;
        end
    end

    assign pulse   = raw_s2_q & ~raw_s3_q;
    assign cnt_inc = (cell_cnt_q == CNT_W'(TIMEOUT)) ? cell_cnt_q : cell_cnt_q + CNT_W'(1);

    // While waiting for the first clock pulse there is no cell to time out.
    assign timeout_hit = (state_q != S_IDLE) && !first_cell_q &&
                         (cell_cnt_q == CNT_W'(TIMEOUT));

    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    always_comb begin
        state_d      = state_q;
        cell_cnt_d   = cnt_inc;
        pre_cnt_d    = pre_cnt_q;
        data_seen_d  = data_seen_q;
        first_cell_d = first_cell_q;
        data_area_d  = data_area_q;
        new_data_d   = 1'b0;
        wr_data_d    = wr_data_q;
        bit_done     = 1'b0;

        if (!gate_s2_q) begin
            state_d      = S_IDLE;
            cell_cnt_d   = '0;
            pre_cnt_d    = '0;
            data_seen_d  = 1'b0;
            first_cell_d = 1'b1;
            data_area_d  = 1'b0;
        end else if (state_q == S_IDLE) begin
            state_d      = S_HUNT;
            cell_cnt_d   = '0;
            pre_cnt_d    = '0;
            data_seen_d  = 1'b0;
            first_cell_d = 1'b1;
        end else if (timeout_hit) begin
            state_d      = S_HUNT;
            cell_cnt_d   = '0;
            pre_cnt_d    = '0;
            data_seen_d  = 1'b0;
            first_cell_d = 1'b1;
            data_area_d  = 1'b0;
        end else if (pulse) begin
            if (first_cell_q) begin
                // Any pulse re-acquires cell phase; the preamble carries clock pulses only.
                cell_cnt_d   = '0;
                data_seen_d  = 1'b0;
                first_cell_d = 1'b0;
            end else if (cell_cnt_q < CNT_W'(DATA_WIN_LO)) begin
                data_seen_d = data_seen_q;
            end else if (cell_cnt_q <= CNT_W'(DATA_WIN_HI)) begin
                data_seen_d = 1'b1;
            end else begin
                cell_cnt_d  = '0;
                data_seen_d = 1'b0;
                bit_done    = 1'b1;
            end
        end

        if (bit_done) begin
            case (state_q)
                S_HUNT: begin
                    if (!data_seen_q) begin
                        if (pre_cnt_q < PRE_W'(MIN_PREAMBLE)) begin
                            pre_cnt_d = pre_cnt_q + PRE_W'(1);
                        end
                    end else if (pre_cnt_q >= PRE_W'(MIN_PREAMBLE)) begin
                        state_d     = S_DATA;
                        data_area_d = 1'b1;
                    end else begin
                        pre_cnt_d = '0;
                    end
                end
                S_DATA: begin
                    new_data_d = 1'b1;
                    wr_data_d  = data_seen_q;
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            cell_cnt_q   <= '0;
            pre_cnt_q    <= '0;
            data_seen_q  <= 1'b0;
            first_cell_q <= 1'b1;
            data_area_q  <= 1'b0;
            new_data_q   <= 1'b0;
            wr_data_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            cell_cnt_q   <= cell_cnt_d;
            pre_cnt_q    <= pre_cnt_d;
            data_seen_q  <= data_seen_d;
            first_cell_q <= first_cell_d;
            data_area_q  <= data_area_d;
            new_data_q   <= new_data_d;
            wr_data_q    <= wr_data_d;
        end
    end

    assign wr_data   = wr_data_q;
    assign new_data  = new_data_q;
    assign data_area = data_area_q;

`ifdef WR_DEC_ERR_EN
    logic err_q;

    // Leaving IDLE with the gate high is exactly the synced gate rising edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_q <= 1'b0;
        end else if (gate_s2_q && state_q == S_IDLE) begin
            err_q <= 1'b0;
        end else if (gate_s2_q && timeout_hit && state_q == S_DATA) begin
            err_q <= 1'b1;
        end
    end

    assign err_missing_clk = err_q;
`endif

endmodule
